// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor.
//
// Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB first,
// through one narrow (DIGIT+1)-bit adder and a single carry flop. An operation
// takes N = WIDTH/DIGIT RUN cycles followed by a one-cycle DONE state.
//
// Handshake: start is sampled on a rising edge only when busy=0 (IDLE or
// DONE); that edge captures a, b, sub and cin. busy is high for the N
// digit cycles, and done pulses high for exactly one cycle when sum, cout
// and ovf have been updated. start seen during DONE begins the next
// operation with no idle cycle in between.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request an operation (ignored while busy)
//   sub        in   0: a+b+cin, 1: a-b (cin ignored)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in for add mode
//   busy       out  digits being processed
//   done       out  one-cycle result-valid pulse
//   sum        out  registered WIDTH-bit result
//   cout       out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf        out  two's-complement overflow
//   dbg_state  out  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT:0]   digit_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] b_eff_d;

  // Subtraction is a + ~b + 1: invert b here and force the carry-in to 1.
  assign b_eff_d = sub ? ~b : b;

  // One digit of the sum plus its carry, from the low digit of each operand.
  assign digit_d = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
                 + (DIGIT+1)'(carry_q);

  // New digit enters the accumulator at the MSB end; after N shifts the
  // first (least significant) digit has reached bit 0. Written as shift/or
  // so it stays valid when DIGIT == WIDTH.
  assign acc_d = (acc_q >> DIGIT)
               | (WIDTH'(digit_d[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            opa_q    <= a;
            opb_q    <= b_eff_d;
            carry_q  <= sub ? 1'b1 : cin;
            sign_a_q <= a[WIDTH-1];
            sign_b_q <= b_eff_d[WIDTH-1];
            cnt_q    <= '0;
            acc_q    <= '0;
            state_q  <= S_RUN;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          opa_q   <= opa_q >> DIGIT;
          opb_q   <= opb_q >> DIGIT;
          carry_q <= digit_d[DIGIT];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sum_q   <= acc_d;
            cout_q  <= digit_d[DIGIT];
            // Overflow: like-signed operands produced a result of the other sign.
            ovf_q   <= (sign_a_q == sign_b_q) && (acc_d[WIDTH-1] != sign_a_q);
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: one instance with DIGIT=1 and one with DIGIT=4,
// both WIDTH=8, sharing operand inputs but with separate start lines.
// Expected results come from constants and from a signed/unsigned integer
// arithmetic model of add/subtract.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sub, cin;
  logic [7:0] a, b;
  logic       start1, start4;

  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic [1:0] dbg1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;
  logic [1:0] dbg4;

  int total = 0;
  int bad   = 0;

  // Expected {ovf, cout, sum} in issue order.
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .ovf(ovf1), .dbg_state(dbg1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .ovf(ovf4), .dbg_state(dbg4)
  );

  // Reference: integer arithmetic on the operand values.
  function automatic logic [9:0] model(input logic [7:0] ia, input logic [7:0] ib,
                                       input logic isub, input logic icin);
    int ua, ub, sa, sb, r, sr;
    logic [7:0] s;
    logic co, ov;
    ua = int'(ia);
    ub = int'(ib);
    sa = $signed(ia);
    sb = $signed(ib);
    if (isub) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + int'(icin);
      co = (r > 255);
      sr = sa + sb + int'(icin);
    end
    ov = (sr > 127) || (sr < -128);
    s  = r[7:0];
    return {ov, co, s};
  endfunction

  // Present operands and pulse start for one edge on the chosen instance.
  task automatic launch(input bit d4, input logic [7:0] ia, input logic [7:0] ib,
                        input logic isub, input logic icin);
    @(negedge clk);
    a = ia; b = ib; sub = isub; cin = icin;
    if (d4) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Advance on negedges until done is seen (bounded), counting busy samples.
  task automatic wait_done(input bit d4, output int busy_cnt, output bit timed_out);
    busy_cnt  = 0;
    timed_out = 1'b0;
    for (int n = 0; n < 40 && (d4 ? done4 : done1) !== 1'b1; n++) begin
      if ((d4 ? busy4 : busy1) === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    if ((d4 ? done4 : done1) !== 1'b1) timed_out = 1'b1;
  endtask

  task automatic test_reset;
    int  bc;
    bit  to;
    bit  seen;
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #1;
    total++; if ({busy1, done1, cout1, ovf1} !== 4'b0) begin bad++;
      $display("FAIL por_flags got=%b exp=0000", {busy1, done1, cout1, ovf1}); end
    total++; if (sum1 !== 8'h00) begin bad++;
      $display("FAIL por_sum got=%h exp=00", sum1); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Leave a non-zero result behind so the mid-run reset has something to clear.
    launch(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done(1'b0, bc, to);
    total++; if (to || sum1 !== 8'h01 || cout1 !== 1'b1) begin bad++;
      $display("FAIL pre_reset_op got sum=%h cout=%b to=%0d exp sum=01 cout=1", sum1, cout1, to); end
    launch(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy1, done1, cout1, ovf1} !== 4'b0) begin bad++;
      $display("FAIL mid_reset_flags got=%b exp=0000", {busy1, done1, cout1, ovf1}); end
    total++; if (sum1 !== 8'h00) begin bad++;
      $display("FAIL mid_reset_sum got=%h exp=00", sum1); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done1 !== 1'b0 || busy1 !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++;
      $display("FAIL post_reset_idle got activity=1 exp=0"); end
  endtask

  task automatic test_add;
    int bc;
    bit to;
    launch(1'b0, 8'h3C, 8'h0F, 1'b0, 1'b0);
    wait_done(1'b0, bc, to);
    total++; if (to || bc != 8) begin bad++;
      $display("FAIL add_latency got busy=%0d to=%0d exp busy=8", bc, to); end
    total++; if ({ovf1, cout1, sum1} !== {1'b0, 1'b0, 8'h4B}) begin bad++;
      $display("FAIL add_3c_0f got=%h/%b/%b exp=4b/0/0", sum1, cout1, ovf1); end
    @(negedge clk);
    total++; if (done1 !== 1'b0) begin bad++;
      $display("FAIL done_one_cycle got=%b exp=0", done1); end
    launch(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1);
    // Previous result must hold while the new operation runs.
    total++; if (sum1 !== 8'h4B || busy1 !== 1'b1) begin bad++;
      $display("FAIL hold_in_run got sum=%h busy=%b exp sum=4b busy=1", sum1, busy1); end
    wait_done(1'b0, bc, to);
    total++; if (to || {ovf1, cout1, sum1} !== {1'b0, 1'b1, 8'h01}) begin bad++;
      $display("FAIL add_ff_01_c got=%h/%b/%b exp=01/1/0", sum1, cout1, ovf1); end
    launch(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(1'b0, bc, to);
    total++; if (to || {ovf1, cout1, sum1} !== {1'b1, 1'b0, 8'h80}) begin bad++;
      $display("FAIL add_7f_01 got=%h/%b/%b exp=80/0/1", sum1, cout1, ovf1); end
  endtask

  task automatic test_sub;
    int bc;
    bit to;
    launch(1'b0, 8'h05, 8'h07, 1'b1, 1'b1);
    wait_done(1'b0, bc, to);
    total++; if (to || {ovf1, cout1, sum1} !== {1'b0, 1'b0, 8'hFE}) begin bad++;
      $display("FAIL sub_05_07 got=%h/%b/%b exp=fe/0/0", sum1, cout1, ovf1); end
    launch(1'b0, 8'h80, 8'h01, 1'b1, 1'b1);
    wait_done(1'b0, bc, to);
    total++; if (to || {ovf1, cout1, sum1} !== {1'b1, 1'b1, 8'h7F}) begin bad++;
      $display("FAIL sub_80_01 got=%h/%b/%b exp=7f/1/1", sum1, cout1, ovf1); end
  endtask

  task automatic test_ignore_start;
    int bc;
    bit to;
    launch(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b1; cin = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b0, bc, to);
    total++; if (to || bc + 3 != 8) begin bad++;
      $display("FAIL ignore_latency got busy=%0d to=%0d exp busy=8", bc + 3, to); end
    total++; if ({ovf1, cout1, sum1} !== {1'b0, 1'b0, 8'h46}) begin bad++;
      $display("FAIL ignore_result got=%h/%b/%b exp=46/0/0", sum1, cout1, ovf1); end
    @(negedge clk);
    total++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin bad++;
      $display("FAIL ignore_no_queue got busy=%b done=%b exp 0/0", busy1, done1); end
  endtask

  task automatic test_back_to_back;
    int bc;
    bit to;
    @(negedge clk);
    a = 8'h40; b = 8'h40; sub = 1'b0; cin = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    wait_done(1'b0, bc, to);
    total++; if (to || {ovf1, cout1, sum1} !== {1'b1, 1'b0, 8'h80}) begin bad++;
      $display("FAIL b2b_first got=%h/%b/%b exp=80/0/1", sum1, cout1, ovf1); end
    // Still in DONE with start high: next edge must accept these operands.
    a = 8'h10; b = 8'h20; sub = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    total++; if (busy1 !== 1'b1) begin bad++;
      $display("FAIL b2b_no_idle got busy=%b exp=1", busy1); end
    wait_done(1'b0, bc, to);
    total++; if (to || bc != 8) begin bad++;
      $display("FAIL b2b_latency got busy=%0d to=%0d exp busy=8", bc, to); end
    total++; if ({ovf1, cout1, sum1} !== {1'b0, 1'b0, 8'hF0}) begin bad++;
      $display("FAIL b2b_second got=%h/%b/%b exp=f0/0/0", sum1, cout1, ovf1); end
  endtask

  task automatic test_digit4;
    int bc;
    bit to;
    launch(1'b1, 8'h9A, 8'h77, 1'b0, 1'b0);
    wait_done(1'b1, bc, to);
    total++; if (to || bc != 2) begin bad++;
      $display("FAIL d4_latency got busy=%0d to=%0d exp busy=2", bc, to); end
    total++; if ({ovf4, cout4, sum4} !== {1'b0, 1'b1, 8'h11}) begin bad++;
      $display("FAIL d4_9a_77 got=%h/%b/%b exp=11/1/0", sum4, cout4, ovf4); end
    launch(1'b1, 8'h80, 8'h01, 1'b1, 1'b0);
    wait_done(1'b1, bc, to);
    total++; if (to || {ovf4, cout4, sum4} !== {1'b1, 1'b1, 8'h7F}) begin bad++;
      $display("FAIL d4_sub_80_01 got=%h/%b/%b exp=7f/1/1", sum4, cout4, ovf4); end
  endtask

  task automatic test_random;
    int         bc;
    bit         to;
    logic [7:0] ra, rb;
    logic       rs, rc;
    logic [9:0] e;
    for (int i = 0; i < 40; i++) begin
      bit d4;
      d4 = (i % 3 == 2);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, rs, rc));
      launch(d4, ra, rb, rs, rc);
      wait_done(d4, bc, to);
      e = exp_q.pop_front();
      total++;
      if (to || bc != (d4 ? 2 : 8)) begin bad++;
        $display("FAIL rand_latency i=%0d got busy=%0d to=%0d", i, bc, to); end
      total++;
      if ((d4 ? {ovf4, cout4, sum4} : {ovf1, cout1, sum1}) !== e) begin bad++;
        $display("FAIL rand_result i=%0d a=%h b=%h sub=%b cin=%b got=%h exp=%h",
                 i, ra, rb, rs, rc, (d4 ? {ovf4, cout4, sum4} : {ovf1, cout1, sum1}), e);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_digit4();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
